// File: rtl/serv_rf_pkg.sv
// -----------------------------------------------------------------------------
// serv_rf_pkg
// Shared definitions for the SRAM-backed SERV register file.
//   - rf_state_e : clear sequencer state encoding (RF_CLEAR, RF_RUN)
//   - rf_depth() : number of RAM words for a given data width / CSR count
//   - rf_aw()    : RAM word address width for a given data width / CSR count
// No ports (package).
// -----------------------------------------------------------------------------
package serv_rf_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // 32 GPRs plus the CSR words, each 32 bits, sliced into width-bit words.
  function automatic int rf_depth(input int width, input int csr_regs);
    return ((32 + csr_regs) * 32) / width;
  endfunction

  function automatic int rf_aw(input int width, input int csr_regs);
    return 5 + $clog2(32 + csr_regs) - $clog2(width);
  endfunction

endpackage

// File: rtl/serv_rf_ram_clr_mem.sv
// -----------------------------------------------------------------------------
// serv_rf_ram_clr_mem
// Plain 1R1W storage array, synchronous write, no reset. The read port is
// combinational so that the owner's output register gives the one-cycle read
// latency; because the write lands on the clock edge, a same-cycle read of the
// written address sees the old contents (read-first).
// Ports:
//   i_clk    in  1    clock
//   i_we     in  1    write enable
//   i_waddr  in  aw   write word address (caller guarantees < depth)
//   i_wdata  in  dw   write word
//   i_raddr  in  aw   read word address (out-of-range results are masked by caller)
//   o_rdata  out dw   word at i_raddr
// -----------------------------------------------------------------------------
module serv_rf_ram_clr_mem #(
  parameter int dw    = 9,
  parameter int depth = 144,
  parameter int aw    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [aw-1:0] i_waddr,
  input  logic [dw-1:0] i_wdata,
  input  logic [aw-1:0] i_raddr,
  output logic [dw-1:0] o_rdata
);

  logic [dw-1:0] mem_q [depth];

  // Array write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/serv_rf_ram_clr.sv
// -----------------------------------------------------------------------------
// serv_rf_ram_clr
// SRAM-backed register-file storage below serv_rf_ram_if. After reset, or on an
// i_clr pulse, a clear sequencer writes zero (with matching zero parity) to
// every word; upstream traffic is ignored while o_busy is high. Each word stores
// one even-parity bit, checked when the word is read back.
// Ports:
//   i_clk    in  1      clock
//   i_rst    in  1      asynchronous reset, active-high
//   i_clr    in  1      single-cycle request to re-run the clear sequence
//   i_waddr  in  aw     write word address
//   i_wdata  in  width  write data
//   i_wen    in  1      write enable
//   i_raddr  in  aw     read word address
//   i_ren    in  1      read enable
//   o_rdata  out width  read data, registered
//   o_perr   out 1      parity error on the word in o_rdata, registered
//   o_busy   out 1      high while clearing
// -----------------------------------------------------------------------------
module serv_rf_ram_clr
  import serv_rf_pkg::*;
#(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int depth    = rf_depth(width, csr_regs),
  parameter int aw       = rf_aw(width, csr_regs)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_perr,
  output logic             o_busy
);

  localparam int              cw        = $clog2(depth);
  localparam logic [aw:0]     depth_lim = (aw + 1)'(depth);
  localparam logic [cw-1:0]   cnt_last  = cw'(depth - 1);
  localparam logic [cw-1:0]   cnt_one   = cw'(1);

  function automatic logic even_parity(input logic [width-1:0] d);
    return ^d;
  endfunction

  rf_state_e        state_q, state_d;
  logic [cw-1:0]    cnt_q, cnt_d;
  logic [width-1:0] rdata_q, rdata_d;
  logic             perr_q, perr_d;

  logic             mem_we;
  logic [aw-1:0]    mem_waddr;
  logic [width:0]   mem_wdata;
  logic [width:0]   mem_rword;
  logic             waddr_ok;
  logic             raddr_ok;

  assign waddr_ok = ({1'b0, i_waddr} < depth_lim);
  assign raddr_ok = ({1'b0, i_raddr} < depth_lim);

  serv_rf_ram_clr_mem #(
    .dw    (width + 1),
    .depth (depth),
    .aw    (aw)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (mem_waddr),
    .i_wdata (mem_wdata),
    .i_raddr (i_raddr),
    .o_rdata (mem_rword)
  );

  // Clear sequencer next-state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (i_clr) begin
          cnt_d = {cw{1'b0}};
        end else if (cnt_q == cnt_last) begin
          state_d = RF_RUN;
          cnt_d   = {cw{1'b0}};
        end else begin
          cnt_d = cnt_q + cnt_one;
        end
      end
      RF_RUN: begin
        if (i_clr) begin
          state_d = RF_CLEAR;
          cnt_d   = {cw{1'b0}};
        end else begin
          state_d = RF_RUN;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = {cw{1'b0}};
      end
    endcase
  end

  // Write port mux: the clear sequencer owns the array while clearing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_waddr;
    mem_wdata = {even_parity(i_wdata), i_wdata};
    if (state_q == RF_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = aw'(cnt_q);
      mem_wdata = {(width + 1){1'b0}};
    end else begin
      mem_we = i_wen & waddr_ok;
    end
  end

  // Read output next-value: load on an accepted read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    perr_d  = perr_q;
    if ((state_q == RF_RUN) && i_ren) begin
      if (raddr_ok) begin
        rdata_d = mem_rword[width-1:0];
        perr_d  = mem_rword[width] ^ even_parity(mem_rword[width-1:0]);
      end else begin
        rdata_d = {width{1'b0}};
        perr_d  = 1'b0;
      end
    end else begin
      rdata_d = rdata_q;
      perr_d  = perr_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= {cw{1'b0}};
      rdata_q <= {width{1'b0}};
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  assign o_rdata = rdata_q;
  assign o_perr  = perr_q;
  assign o_busy  = (state_q == RF_CLEAR);

endmodule

// File: tb/tb_serv_rf_ram_clr.sv
// -----------------------------------------------------------------------------
// tb_serv_rf_ram_clr
// Self-checking bench for serv_rf_ram_clr with default parameters (width 8,
// 144 words, 8-bit addresses). A reference array of word values plus a
// per-word "corrupted" flag predicts every read result.
// -----------------------------------------------------------------------------
module tb_serv_rf_ram_clr;

  localparam int DEPTH = 144;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       wen;
  logic [7:0] raddr;
  logic       ren;
  logic [7:0] rdata;
  logic       perr;
  logic       busy;

  int n_checks;
  int n_pass;

  // Reference model
  logic [7:0] model_mem [DEPTH];
  logic       model_bad [DEPTH];
  logic [7:0] exp_rdata;
  logic       exp_perr;

  serv_rf_ram_clr dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (clr),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_wen   (wen),
    .i_raddr (raddr),
    .i_ren   (ren),
    .o_rdata (rdata),
    .o_perr  (perr),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 8'h00;
      model_bad[i] = 1'b0;
    end
  endtask

  // Called at a negedge while busy: counts cycles until busy drops.
  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd144);
  endtask

  // One RUN cycle, called at a negedge; checks outputs at the next negedge.
  task automatic step(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                      input logic r, input logic [7:0] ra, input string tag);
    wen   = w;
    waddr = wa;
    wdata = wd;
    ren   = r;
    raddr = ra;
    @(posedge clk);
    if (r) begin
      if (int'(ra) < DEPTH) begin
        exp_rdata = model_mem[ra];
        exp_perr  = model_bad[ra];
      end else begin
        exp_rdata = 8'h00;
        exp_perr  = 1'b0;
      end
    end
    if (w && int'(wa) < DEPTH) begin
      model_mem[wa] = wd;
      model_bad[wa] = 1'b0;
    end
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
    chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
    chk({tag, "_perr"}, 32'(perr), 32'(exp_perr));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    wen       = 1'b0;
    ren       = 1'b0;
    waddr     = 8'h00;
    wdata     = 8'h00;
    raddr     = 8'h00;
    exp_rdata = 8'h00;
    exp_perr  = 1'b0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);

    // 1: clear after reset release takes 144 cycles, all words read zero
    rst = 1'b0;
    wait_clear("clear_len_rst");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1, 8'(i), "init_zero");
    end

    // 2: write then read back
    step(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, "wr10");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, "rd10");

    // 3: same-cycle read and write of one address is read-first
    step(1'b1, 8'h20, 8'h11, 1'b0, 8'h00, "wr20a");
    step(1'b1, 8'h20, 8'h3C, 1'b1, 8'h20, "rw20");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, "rd20");

    // Out-of-range write is dropped, read returns zero
    step(1'b1, 8'd200, 8'hFF, 1'b1, 8'h10, "wr_oor");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'd200, "rd_oor");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'd143, "rd_last");

    // 4: corrupt a stored data bit of word 5
    step(1'b1, 8'h05, 8'h5A, 1'b0, 8'h00, "wr05");
    dut.u_mem.mem_q[5][0] = ~dut.u_mem.mem_q[5][0];
    model_mem[5] = model_mem[5] ^ 8'h01;
    model_bad[5] = 1'b1;
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h05, "rd05_perr");
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "hold_perr");

    // Randomized traffic, including out-of-range addresses and idle reads
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 175)), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 175)), "rand");
    end

    // Make sure a nonzero value is held going into the clear
    step(1'b1, 8'h40, 8'h96, 1'b0, 8'h00, "wr40");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h40, "rd40");

    // 5: clear from RUN, restart at clear cycle 50, upstream ignored meanwhile
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    wen   = 1'b1;
    waddr = 8'h30;
    wdata = 8'hFF;
    ren   = 1'b1;
    raddr = 8'h40;
    clr   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_clear("clear_len_restart");
    wen = 1'b0;
    ren = 1'b0;
    chk("clear_hold_rdata", 32'(rdata), 32'(exp_rdata));
    model_clear();
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h30, "rd30_cleared");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h40, "rd40_cleared");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h05, "rd05_cleared");

    // 6: asynchronous reset mid-cycle in RUN
    step(1'b1, 8'h22, 8'hC3, 1'b0, 8'h00, "wr22");
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h22, "rd22");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd1);
    chk("async_rst_rdata", 32'(rdata), 32'd0);
    chk("async_rst_perr", 32'(perr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 8'h00;
    exp_perr  = 1'b0;
    wait_clear("clear_len_rerst");
    model_clear();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1, 8'($urandom_range(0, 143)), "rerst_zero");
    end
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h22, "rd22_cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
